// File: rtl/st_dma_ctrl.sv
// Atari ST DMA controller register block: CPU register decode, FDC strobe
// generation, and DMA address / sector-count bookkeeping for 16-byte blocks.
module st_dma_ctrl #(
  parameter int BLOCKS_PER_SECTOR = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_sel,
  input  logic        cpu_rw,
  input  logic [2:0]  cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        fdc_sel,
  output logic        fdc_rw,
  output logic [1:0]  fdc_addr,
  output logic [7:0]  fdc_din,
  input  logic [7:0]  fdc_dout,
  input  logic        io_block_done,
  output logic [23:0] dma_addr,
  output logic        dma_dir,
  output logic [7:0]  dma_sector_cnt
);

  localparam int BW = (BLOCKS_PER_SECTOR > 1) ? $clog2(BLOCKS_PER_SECTOR) : 1;
  localparam logic [BW-1:0] BLK_LAST = BW'(BLOCKS_PER_SECTOR - 1);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_LATCH, S_HOLD} fdc_state_t;

  fdc_state_t    state, state_nxt;
  logic          sel_d;
  logic [8:0]    mode;
  logic [7:0]    sector_cnt;
  logic [BW-1:0] blk_cnt;
  logic          error;
  logic [7:0]    rd_latch;
  logic          start, wr, fdc_access;
  logic          unused_bits;

  // One action per CPU bus cycle: only the rising edge of cpu_sel counts.
  assign start      = cpu_sel & ~sel_d;
  assign wr         = start & ~cpu_rw;
  assign fdc_access = start & (cpu_addr == 3'd2) & ~mode[4] & ~mode[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fdc_access) state_nxt = S_STROBE;
      S_STROBE: state_nxt = fdc_rw ? S_LATCH : S_HOLD;
      S_LATCH:  state_nxt = S_HOLD;
      S_HOLD:   if (!cpu_sel) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fdc_sel  <= 1'b0;
      fdc_rw   <= 1'b1;
      fdc_addr <= 2'd0;
      fdc_din  <= 8'd0;
      rd_latch <= 8'd0;
    end else begin
      fdc_sel <= (state == S_IDLE) && fdc_access;
      if ((state == S_IDLE) && fdc_access) begin
        fdc_rw   <= cpu_rw;
        fdc_addr <= mode[2:1];
        fdc_din  <= cpu_din[7:0];
      end
      if ((state == S_STROBE) && fdc_rw) rd_latch <= fdc_dout;
    end
  end

  // Block-done updates first; a same-clock CPU write then overrides only the
  // fields it targets, so the untouched fields keep the block-done update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_d      <= 1'b0;
      mode       <= 9'd0;
      sector_cnt <= 8'd0;
      blk_cnt    <= '0;
      error      <= 1'b0;
      dma_addr   <= 24'd0;
    end else begin
      sel_d <= cpu_sel;
      if (io_block_done) begin
        if (sector_cnt == 8'd0) begin
          error <= 1'b1;
        end else begin
          dma_addr <= dma_addr + 24'd16;
          if (blk_cnt == BLK_LAST) begin
            blk_cnt    <= '0;
            sector_cnt <= sector_cnt - 8'd1;
          end else begin
            blk_cnt <= blk_cnt + BW'(1);
          end
        end
      end
      if (wr) begin
        case (cpu_addr)
          3'd2: if (mode[4]) begin
            sector_cnt <= cpu_din[7:0];
            blk_cnt    <= '0;
            error      <= 1'b0;
          end
          3'd3: begin
            mode <= cpu_din[8:0];
            if (cpu_din[8] != mode[8]) begin
              blk_cnt <= '0;
              error   <= 1'b0;
            end
          end
          3'd4: dma_addr[23:16] <= cpu_din[7:0];
          3'd5: dma_addr[15:8]  <= cpu_din[7:0];
          3'd6: dma_addr[7:1]   <= cpu_din[7:1];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cpu_dout = 16'd0;
    if (cpu_sel && cpu_rw) begin
      case (cpu_addr)
        3'd2: begin
          if (mode[4])                          cpu_dout = {8'h00, sector_cnt};
          else if (!mode[3] && state == S_HOLD) cpu_dout = {8'h00, rd_latch};
        end
        3'd3:    cpu_dout = {13'd0, 1'b0, sector_cnt != 8'd0, ~error};
        3'd4:    cpu_dout = {8'h00, dma_addr[23:16]};
        3'd5:    cpu_dout = {8'h00, dma_addr[15:8]};
        3'd6:    cpu_dout = {8'h00, dma_addr[7:0]};
        default: cpu_dout = 16'd0;
      endcase
    end
  end

  assign dma_dir        = mode[8];
  assign dma_sector_cnt = sector_cnt;
  assign unused_bits    = ^{cpu_din[15:9], mode[7:5], mode[0]};

endmodule

// File: tb/tb_st_dma_ctrl.sv
// Directed bench for st_dma_ctrl: register access, FDC strobes, block counting.
module tb_st_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_sel, cpu_rw;
  logic [2:0]  cpu_addr;
  logic [15:0] cpu_din, cpu_dout;
  logic        fdc_sel, fdc_rw;
  logic [1:0]  fdc_addr;
  logic [7:0]  fdc_din, fdc_dout;
  logic        io_block_done;
  logic [23:0] dma_addr;
  logic        dma_dir;
  logic [7:0]  dma_sector_cnt;

  logic [7:0]  fdc_model = 8'h00;
  int          fdc_pulses = 0;
  logic        cap_rw;
  logic [1:0]  cap_addr;
  logic [7:0]  cap_din;
  int          test_cnt = 0;
  int          fail_cnt = 0;

  always #5 clk = ~clk;

  st_dma_ctrl #(.BLOCKS_PER_SECTOR(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_sel(cpu_sel), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .fdc_sel(fdc_sel), .fdc_rw(fdc_rw), .fdc_addr(fdc_addr),
    .fdc_din(fdc_din), .fdc_dout(fdc_dout),
    .io_block_done(io_block_done),
    .dma_addr(dma_addr), .dma_dir(dma_dir), .dma_sector_cnt(dma_sector_cnt)
  );

  // FDC model: data only while selected; strobes counted and captured.
  assign fdc_dout = fdc_sel ? fdc_model : 8'h00;

  always @(negedge clk) begin
    if (fdc_sel) begin
      fdc_pulses <= fdc_pulses + 1;
      cap_rw     <= fdc_rw;
      cap_addr   <= fdc_addr;
      cap_din    <= fdc_din;
    end
  end

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d, input int hold);
    @(negedge clk);
    cpu_sel = 1'b1; cpu_rw = 1'b0; cpu_addr = a; cpu_din = d;
    repeat (hold) @(negedge clk);
    cpu_sel = 1'b0; cpu_rw = 1'b1; cpu_din = 16'h0;
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [2:0] a, input int hold, output logic [15:0] d);
    @(negedge clk);
    cpu_sel = 1'b1; cpu_rw = 1'b1; cpu_addr = a;
    repeat (hold) @(negedge clk);
    d = cpu_dout;
    cpu_sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic blk_pulses(input int n);
    repeat (n) begin
      @(negedge clk); io_block_done = 1'b1;
      @(negedge clk); io_block_done = 1'b0;
    end
  endtask

  task automatic test_reset;
    logic [15:0] d;
    cpu_write(3'd4, 16'h00AB, 1);
    cpu_write(3'd3, 16'h0190, 1);
    cpu_write(3'd2, 16'h0005, 1);
    cpu_write(3'd3, 16'h0180, 1);
    @(negedge clk);
    cpu_sel = 1'b1; cpu_rw = 1'b0; cpu_addr = 3'd2; cpu_din = 16'h0055;
    @(posedge clk); #2;
    test_cnt++;
    if (fdc_sel !== 1'b1) begin fail_cnt++; $display("FAIL reset_pre_strobe: fdc_sel=%b want 1", fdc_sel); end
    reset_n = 1'b0;
    #1;
    test_cnt++;
    if (fdc_sel !== 1'b0) begin fail_cnt++; $display("FAIL reset_abort_strobe: fdc_sel=%b want 0", fdc_sel); end
    cpu_sel = 1'b0; cpu_din = 16'h0; cpu_rw = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_cnt++;
    if ({dma_addr, dma_dir, dma_sector_cnt, fdc_sel, fdc_rw, fdc_addr, fdc_din, cpu_dout} !==
        {24'h0, 1'b0, 8'h0, 1'b0, 1'b1, 2'd0, 8'h0, 16'h0}) begin
      fail_cnt++;
      $display("FAIL reset_outputs: addr=%h dir=%b cnt=%h sel=%b rw=%b fa=%h fd=%h dout=%h want 0 except rw=1",
               dma_addr, dma_dir, dma_sector_cnt, fdc_sel, fdc_rw, fdc_addr, fdc_din, cpu_dout);
    end
    cpu_read(3'd3, 1, d);
    test_cnt++;
    if (d !== 16'h0001) begin fail_cnt++; $display("FAIL reset_status: got %h want 0001", d); end
  endtask

  task automatic test_fdc_write;
    int p0;
    cpu_write(3'd3, 16'h0080, 1);
    p0 = fdc_pulses;
    cpu_write(3'd2, 16'h0080, 10);
    @(negedge clk);
    test_cnt++;
    if (fdc_pulses - p0 != 1) begin fail_cnt++; $display("FAIL fdcw_pulses: got %0d want 1", fdc_pulses - p0); end
    test_cnt++;
    if ({cap_rw, cap_addr, cap_din} !== {1'b0, 2'd0, 8'h80}) begin
      fail_cnt++; $display("FAIL fdcw_fields: rw=%b addr=%0d din=%h want rw=0 addr=0 din=80", cap_rw, cap_addr, cap_din);
    end
  endtask

  task automatic test_fdc_read;
    int p0;
    cpu_write(3'd3, 16'h0082, 1);
    fdc_model = 8'h4F;
    p0 = fdc_pulses;
    @(negedge clk);
    cpu_sel = 1'b1; cpu_rw = 1'b1; cpu_addr = 3'd2;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 2) begin
        test_cnt++;
        if (cpu_dout !== 16'h0000) begin fail_cnt++; $display("FAIL fdcr_early clk%0d: got %h want 0000", i, cpu_dout); end
      end else if (i >= 3) begin
        test_cnt++;
        if (cpu_dout !== 16'h004F) begin fail_cnt++; $display("FAIL fdcr_data clk%0d: got %h want 004F", i, cpu_dout); end
      end
    end
    cpu_sel = 1'b0;
    fdc_model = 8'h00;
    @(negedge clk);
    test_cnt++;
    if (cpu_dout !== 16'h0000) begin fail_cnt++; $display("FAIL fdcr_desel: got %h want 0000", cpu_dout); end
    test_cnt++;
    if (fdc_pulses - p0 != 1) begin fail_cnt++; $display("FAIL fdcr_pulses: got %0d want 1", fdc_pulses - p0); end
    test_cnt++;
    if ({cap_rw, cap_addr} !== {1'b1, 2'd1}) begin
      fail_cnt++; $display("FAIL fdcr_fields: rw=%b addr=%0d want rw=1 addr=1", cap_rw, cap_addr);
    end
  endtask

  task automatic test_hdc;
    int p0;
    logic [15:0] d;
    cpu_write(3'd3, 16'h0088, 1);
    p0 = fdc_pulses;
    cpu_write(3'd2, 16'h00AA, 3);
    cpu_read(3'd2, 4, d);
    @(negedge clk);
    test_cnt++;
    if (fdc_pulses - p0 != 0) begin fail_cnt++; $display("FAIL hdc_pulses: got %0d want 0", fdc_pulses - p0); end
    test_cnt++;
    if (d !== 16'h0000) begin fail_cnt++; $display("FAIL hdc_read: got %h want 0000", d); end
  endtask

  task automatic test_addr_regs;
    logic [15:0] d;
    cpu_write(3'd4, 16'hFF12, 1);
    cpu_write(3'd5, 16'h0034, 1);
    cpu_write(3'd6, 16'h0057, 1);
    test_cnt++;
    if (dma_addr !== 24'h123456) begin fail_cnt++; $display("FAIL addr_load: got %h want 123456", dma_addr); end
    cpu_read(3'd6, 1, d);
    test_cnt++;
    if (d !== 16'h0056) begin fail_cnt++; $display("FAIL addr_lo_read: got %h want 0056", d); end
    cpu_read(3'd4, 2, d);
    test_cnt++;
    if (d !== 16'h0012) begin fail_cnt++; $display("FAIL addr_hi_read: got %h want 0012", d); end
    cpu_read(3'd0, 1, d);
    test_cnt++;
    if (d !== 16'h0000) begin fail_cnt++; $display("FAIL read_addr0: got %h want 0000", d); end
    cpu_read(3'd7, 1, d);
    test_cnt++;
    if (d !== 16'h0000) begin fail_cnt++; $display("FAIL read_addr7: got %h want 0000", d); end
  endtask

  task automatic test_sector_count;
    logic [15:0] d;
    cpu_write(3'd3, 16'h0090, 1);
    cpu_write(3'd2, 16'h0002, 1);
    cpu_write(3'd4, 16'h0000, 1);
    cpu_write(3'd5, 16'h0010, 1);
    cpu_write(3'd6, 16'h0000, 1);
    cpu_read(3'd2, 1, d);
    test_cnt++;
    if (d !== 16'h0002) begin fail_cnt++; $display("FAIL cnt_read: got %h want 0002", d); end
    blk_pulses(31);
    test_cnt++;
    if (dma_sector_cnt !== 8'd2) begin fail_cnt++; $display("FAIL cnt_31: got %0d want 2", dma_sector_cnt); end
    blk_pulses(1);
    test_cnt++;
    if ({dma_sector_cnt, dma_addr} !== {8'd1, 24'h001200}) begin
      fail_cnt++; $display("FAIL cnt_32: cnt=%0d addr=%h want 1 001200", dma_sector_cnt, dma_addr);
    end
    blk_pulses(31);
    test_cnt++;
    if (dma_sector_cnt !== 8'd1) begin fail_cnt++; $display("FAIL cnt_63: got %0d want 1", dma_sector_cnt); end
    blk_pulses(1);
    test_cnt++;
    if ({dma_sector_cnt, dma_addr} !== {8'd0, 24'h001400}) begin
      fail_cnt++; $display("FAIL cnt_64: cnt=%0d addr=%h want 0 001400", dma_sector_cnt, dma_addr);
    end
    cpu_read(3'd3, 1, d);
    test_cnt++;
    if (d !== 16'h0001) begin fail_cnt++; $display("FAIL cnt_status: got %h want 0001", d); end
  endtask

  task automatic test_overrun;
    logic [15:0] d;
    blk_pulses(1);
    cpu_read(3'd3, 1, d);
    test_cnt++;
    if (d !== 16'h0000) begin fail_cnt++; $display("FAIL ovr_status: got %h want 0000", d); end
    test_cnt++;
    if (dma_addr !== 24'h001400) begin fail_cnt++; $display("FAIL ovr_addr: got %h want 001400", dma_addr); end
    cpu_write(3'd3, 16'h0190, 1);
    cpu_read(3'd3, 1, d);
    test_cnt++;
    if ({d, dma_dir} !== {16'h0001, 1'b1}) begin
      fail_cnt++; $display("FAIL ovr_toggle: status=%h dir=%b want 0001 1", d, dma_dir);
    end
  endtask

  task automatic test_wrap_collision;
    cpu_write(3'd2, 16'h0001, 1);
    cpu_write(3'd4, 16'h00FF, 1);
    cpu_write(3'd5, 16'h00FF, 1);
    cpu_write(3'd6, 16'h00F0, 1);
    blk_pulses(1);
    test_cnt++;
    if (dma_addr !== 24'h000000) begin fail_cnt++; $display("FAIL wrap_addr: got %h want 000000", dma_addr); end
    @(negedge clk);
    cpu_sel = 1'b1; cpu_rw = 1'b0; cpu_addr = 3'd6; cpu_din = 16'h0020; io_block_done = 1'b1;
    @(negedge clk);
    io_block_done = 1'b0; cpu_sel = 1'b0; cpu_rw = 1'b1; cpu_din = 16'h0;
    @(negedge clk);
    test_cnt++;
    if (dma_addr !== 24'h000020) begin fail_cnt++; $display("FAIL coll_addr: got %h want 000020", dma_addr); end
    // Two blocks counted so far; the 32nd block must end the sector.
    blk_pulses(29);
    test_cnt++;
    if ({dma_sector_cnt, dma_addr} !== {8'd1, 24'h0001F0}) begin
      fail_cnt++; $display("FAIL coll_blk31: cnt=%0d addr=%h want 1 0001F0", dma_sector_cnt, dma_addr);
    end
    blk_pulses(1);
    test_cnt++;
    if ({dma_sector_cnt, dma_addr} !== {8'd0, 24'h000200}) begin
      fail_cnt++; $display("FAIL coll_blk32: cnt=%0d addr=%h want 0 000200", dma_sector_cnt, dma_addr);
    end
  endtask

  initial begin
    reset_n = 1'b0; cpu_sel = 1'b0; cpu_rw = 1'b1; cpu_addr = 3'd0;
    cpu_din = 16'h0; io_block_done = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_fdc_write();
    test_fdc_read();
    test_hdc();
    test_addr_regs();
    test_sector_count();
    test_overrun();
    test_wrap_collision();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
